dma_read_arb: RTL and testbench
===============================

Name: dma_read_arb

Overview:
- Round-robin arbiter and sequencer that shares the single DMA read channel (read_req / read_data handshake) among NUM_REQ requesters, e.g. query and database fetch engines of the Smith-Waterman array.
- Grants one requester at a time, issues its request to the DMA engine, then owns the data phase until every 64-byte beat of that transfer is acknowledged.
- Sits between the requesters and the dma read port, alongside job/mmio control.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the owner index; must satisfy 2^ID_W >= NUM_REQ.
- BEAT_BYTES_LOG2, 6, log2 of bytes per 512-bit data beat.

Ports:
- ha_pclock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until req_grant.
- req_addr  in  64*NUM_REQ  per-requester byte address; slice i = bits [64i +: 64].
- req_size  in  64*NUM_REQ  per-requester byte count; same slicing.
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse when the request is issued to DMA.
- req_data_valid  out  NUM_REQ  one-hot, beat available to the owner.
- req_data_ack  in  NUM_REQ  owner consumes the beat.
- req_data  out  512  beat data, broadcast to all requesters.
- req_done  out  NUM_REQ  one-hot, one-cycle pulse after the owner's last beat.
- read_ready  in  1  DMA can accept a read request.
- read_req  out  1  DMA read request strobe.
- read_addr  out  64  latched address.
- read_size  out  64  latched size.
- read_data_ready  in  1  DMA has a beat.
- read_data  in  512  DMA beat data.
- read_data_ack  out  1  beat consumed.
- busy  out  1  state != IDLE.
- owner  out  ID_W  index of the current or last owner.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer rr = 0; beat counter = 0; latched addr/size = 0. Reset is synchronous and overrides everything.
- A DMA transfer already in flight when reset asserts is not cancelled here; the dma block is reset by the same signal.

State IDLE:
- If any req_valid bit is set, pick the first set bit searching rr, rr+1, ... (mod NUM_REQ).
- Latch owner, addr, size, and beats = (size + 63) >> 6 (full 64-bit arithmetic, 58-bit counter).
- If size == 0: pulse req_grant[owner] and req_done[owner] in the next cycle with no DMA request, set rr = owner+1 mod NUM_REQ, and stay in IDLE for that cycle.
- Otherwise go to ISSUE.

State ISSUE:
- read_addr and read_size drive the latched values.
- read_req = read_ready (combinational, single cycle), with req_grant[owner] = 1 in the same cycle; then go to DATA.
- If read_ready stays low, wait indefinitely.

State DATA:
- req_data_valid[owner] = read_data_ready; req_data = read_data.
- read_data_ack = read_data_ready & req_data_ack[owner]; acks from non-owners are ignored.
- Each ack decrements beats.
- On the ack with beats == 1: req_done[owner] pulses the next cycle, rr = owner+1 mod NUM_REQ, and the state returns to IDLE.

Timing and boundary rules:
- Minimum latency from req_valid (IDLE) to read_req is 1 cycle.
- There is one IDLE bubble between consecutive transfers.
- Requests arriving in ISSUE or DATA are held off; requesters keep req_valid high.
- Dropping req_valid before grant is legal; the arbitration is re-evaluated every IDLE cycle. After latch the request is committed.
- Wrap-around: with rr = NUM_REQ-1, the search order is NUM_REQ-1, 0, 1, ...
- req_data_valid, req_grant and req_done are never asserted for more than one requester.

Test Plan:
- Single request: requester 1, addr 0x1000, size 128, read_ready=1 -> read_req one cycle after req_valid with read_addr 0x1000, read_size 128; req_grant=0b0010; two acked beats; req_done[1] one cycle after the second ack; rr=2.
- Fairness: all four requesters valid continuously, size 64 each -> grant order 0, 1, 2, 3, 0; the second round starts at 0 via wrap.
- Backpressure: read_ready held 0 for 10 cycles in ISSUE -> read_req stays 0 and busy=1; read_req and grant fire in the cycle read_ready rises.
- Beat rounding and foreign acks: size 65 -> exactly 2 beats. req_data_ack asserted on a non-owner -> read_data_ack stays 0 and the counter is unchanged.
- Zero size: requester 2, size 0 -> req_grant[2] and req_done[2] pulse, read_req never asserted, next arbitration starts from 3.
- Reset mid-DATA: assert reset after 1 of 4 beats -> next cycle all outputs 0, state IDLE, rr=0; a new request is served normally after reset deasserts.

Source files
------------

// File: rtl/dma_read_arb.sv
// Round-robin arbiter and sequencer sharing one DMA read channel among NUM_REQ requesters.
// A granted requester owns the data phase until every beat of its transfer is acknowledged.
module dma_read_arb #(
    parameter int NUM_REQ         = 4,
    parameter int ID_W            = 2,
    parameter int BEAT_BYTES_LOG2 = 6
) (
    input  logic                    ha_pclock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [64*NUM_REQ-1:0]   req_addr,
    input  logic [64*NUM_REQ-1:0]   req_size,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [NUM_REQ-1:0]      req_data_valid,
    input  logic [NUM_REQ-1:0]      req_data_ack,
    output logic [511:0]            req_data,
    output logic [NUM_REQ-1:0]      req_done,
    input  logic                    read_ready,
    output logic                    read_req,
    output logic [63:0]             read_addr,
    output logic [63:0]             read_size,
    input  logic                    read_data_ready,
    input  logic [511:0]            read_data,
    output logic                    read_data_ack,
    output logic                    busy,
    output logic [ID_W-1:0]         owner
);

    localparam int CNT_W = 64 - BEAT_BYTES_LOG2;
    localparam logic [63:0] ROUND_ADD = (64'd1 << BEAT_BYTES_LOG2) - 64'd1;
    localparam logic [CNT_W-1:0] ONE_BEAT = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t               state_r;
    logic [ID_W-1:0]      rr_r;
    logic [ID_W-1:0]      owner_r;
    logic [63:0]          addr_r;
    logic [63:0]          size_r;
    logic [CNT_W-1:0]     beats_r;
    logic [NUM_REQ-1:0]   zero_grant_r;
    logic [NUM_REQ-1:0]   done_r;

    logic                 pick_found_s;
    logic [ID_W-1:0]      pick_idx_s;
    logic [63:0]          pick_addr_s;
    logic [63:0]          pick_size_s;
    logic [63:0]          round_sum_s;
    logic [CNT_W-1:0]     pick_beats_s;
    logic [NUM_REQ-1:0]   owner_onehot_s;
    logic                 owner_ack_s;
    logic                 data_ack_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        if (idx == ID_W'(NUM_REQ - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = idx + {{(ID_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Round-robin search: first valid requester starting at rr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] cand;
        logic          hit;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand         = '0;
        hit          = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_r} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            hit = (|(req_valid & onehot(cand[ID_W-1:0]))) & ~pick_found_s;
            if (hit) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand[ID_W-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Select the chosen requester's address and size slices.
    always_comb begin
        pick_addr_s = '0;
        pick_size_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_s == ID_W'(i)) begin
                pick_addr_s = req_addr[64*i +: 64];
                pick_size_s = req_size[64*i +: 64];
            end else begin
                pick_addr_s = pick_addr_s;
            end
        end
    end

    // The rounding add deliberately wraps in 64 bits before the shift.
    assign round_sum_s    = pick_size_s + ROUND_ADD;
    assign pick_beats_s   = round_sum_s[63:BEAT_BYTES_LOG2];
    assign owner_onehot_s = onehot(owner_r);
    assign owner_ack_s    = |(req_data_ack & owner_onehot_s);
    assign data_ack_s     = (state_r == DATA) & read_data_ready & owner_ack_s;

    // Arbitration, latching and transfer sequencing FSM.
    always_ff @(posedge ha_pclock) begin
        if (reset) begin
            state_r      <= IDLE;
            rr_r         <= '0;
            owner_r      <= '0;
            addr_r       <= '0;
            size_r       <= '0;
            beats_r      <= '0;
            zero_grant_r <= '0;
            done_r       <= '0;
        end else begin
            zero_grant_r <= '0;
            done_r       <= '0;
            case (state_r)
                IDLE: begin
                    // A zero-size grant is still pulsing this cycle, so its requester may still be valid.
                    if (pick_found_s && (zero_grant_r == '0)) begin
                        owner_r <= pick_idx_s;
                        addr_r  <= pick_addr_s;
                        size_r  <= pick_size_s;
                        beats_r <= pick_beats_s;
                        if (pick_size_s == 64'd0) begin
                            zero_grant_r <= onehot(pick_idx_s);
                            done_r       <= onehot(pick_idx_s);
                            rr_r         <= next_idx(pick_idx_s);
                        end else begin
                            state_r <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (read_ready) begin
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (data_ack_s) begin
                        beats_r <= beats_r - ONE_BEAT;
                        if (beats_r == ONE_BEAT) begin
                            done_r  <= owner_onehot_s;
                            rr_r    <= next_idx(owner_r);
                            state_r <= IDLE;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign busy           = (state_r != IDLE);
    assign read_req       = (state_r == ISSUE) & read_ready;
    assign req_grant      = zero_grant_r | (read_req ? owner_onehot_s : '0);
    assign req_data_valid = ((state_r == DATA) & read_data_ready) ? owner_onehot_s : '0;
    assign read_data_ack  = data_ack_s;
    assign req_data       = (state_r == DATA) ? read_data : '0;
    assign req_done       = done_r;
    assign read_addr      = addr_r;
    assign read_size      = size_r;
    assign owner          = owner_r;

endmodule

// File: tb/tb_dma_read_arb.sv
// Directed, table-driven bench for dma_read_arb: single transfers from a vector table,
// then hand-written sequences for fairness, backpressure, foreign acks, zero size and reset.
module tb_dma_read_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  ha_pclock = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [64*NUM_REQ-1:0] req_addr;
    logic [64*NUM_REQ-1:0] req_size;
    logic [NUM_REQ-1:0]    req_grant;
    logic [NUM_REQ-1:0]    req_data_valid;
    logic [NUM_REQ-1:0]    req_data_ack;
    logic [511:0]          req_data;
    logic [NUM_REQ-1:0]    req_done;
    logic                  read_ready;
    logic                  read_req;
    logic [63:0]           read_addr;
    logic [63:0]           read_size;
    logic                  read_data_ready;
    logic [511:0]          read_data;
    logic                  read_data_ack;
    logic                  busy;
    logic [ID_W-1:0]       owner;

    dma_read_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .BEAT_BYTES_LOG2(6)) dut (
        .ha_pclock(ha_pclock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
        .req_grant(req_grant), .req_data_valid(req_data_valid),
        .req_data_ack(req_data_ack), .req_data(req_data), .req_done(req_done),
        .read_ready(read_ready), .read_req(read_req), .read_addr(read_addr),
        .read_size(read_size), .read_data_ready(read_data_ready),
        .read_data(read_data), .read_data_ack(read_data_ack),
        .busy(busy), .owner(owner)
    );

    always #5 ha_pclock = ~ha_pclock;

    typedef struct {
        int          id;
        logic [63:0] addr;
        logic [63:0] size;
        int          beats;
    } vec_t;

    vec_t vecs[5];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ha_pclock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(4'b0001 << i);
    endfunction

    function automatic logic [511:0] pat(input int b);
        return {16{32'hC0DE_0000 + 32'(b)}};
    endfunction

    task automatic idle_inputs();
        req_valid       = '0;
        req_data_ack    = '0;
        read_ready      = 1'b1;
        read_data_ready = 1'b0;
        read_data       = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 512'(req_grant), 512'(4'b0));
        chk({tag, "_dvalid"}, 512'(req_data_valid), 512'(4'b0));
        chk({tag, "_done"}, 512'(req_done), 512'(4'b0));
        chk({tag, "_read_req"}, 512'(read_req), 512'(1'b0));
        chk({tag, "_read_addr"}, 512'(read_addr), 512'(64'd0));
        chk({tag, "_read_size"}, 512'(read_size), 512'(64'd0));
        chk({tag, "_read_data_ack"}, 512'(read_data_ack), 512'(1'b0));
        chk({tag, "_req_data"}, req_data, 512'd0);
        chk({tag, "_busy"}, 512'(busy), 512'(1'b0));
        chk({tag, "_owner"}, 512'(owner), 512'(2'd0));
        chk({tag, "_rr"}, 512'(dut.rr_r), 512'(2'd0));
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One complete transfer for a single requester with an always-ready DMA.
    task automatic do_xfer(input int id, input logic [63:0] addr, input logic [63:0] size,
                           input int beats);
        tick();
        req_valid = oh(id);
        req_addr[64*id +: 64] = addr;
        req_size[64*id +: 64] = size;
        read_ready = 1'b1;
        settle();
        chk("idle_read_req", 512'(read_req), 512'(1'b0));
        chk("idle_busy", 512'(busy), 512'(1'b0));
        tick();
        settle();
        chk("issue_read_req", 512'(read_req), 512'(1'b1));
        chk("issue_grant", 512'(req_grant), 512'(oh(id)));
        chk("issue_addr", 512'(read_addr), 512'(addr));
        chk("issue_size", 512'(read_size), 512'(size));
        chk("issue_owner", 512'(owner), 512'(id));
        req_valid = '0;
        for (int b = 0; b < beats; b++) begin
            tick();
            read_data_ready = 1'b1;
            req_data_ack    = oh(id);
            read_data       = pat(b);
            settle();
            chk("beat_dvalid", 512'(req_data_valid), 512'(oh(id)));
            chk("beat_ack", 512'(read_data_ack), 512'(1'b1));
            chk("beat_data", req_data, pat(b));
            chk("beat_no_done", 512'(req_done), 512'(4'b0));
            chk("beat_busy", 512'(busy), 512'(1'b1));
        end
        tick();
        read_data_ready = 1'b0;
        req_data_ack    = '0;
        settle();
        chk("xfer_done", 512'(req_done), 512'(oh(id)));
        chk("xfer_idle", 512'(busy), 512'(1'b0));
        chk("xfer_rr", 512'(dut.rr_r), 512'((id + 1) % NUM_REQ));
    endtask

    initial begin
        int order[5];
        int exp_order[5];
        int ngr;
        int bad;
        int gi;

        vecs[0] = '{id: 1, addr: 64'h0000_0000_0000_1000, size: 64'd128, beats: 2};
        vecs[1] = '{id: 3, addr: 64'hDEAD_BEEF_0000_0040, size: 64'd65,  beats: 2};
        vecs[2] = '{id: 0, addr: 64'h0000_0000_0000_2000, size: 64'd64,  beats: 1};
        vecs[3] = '{id: 2, addr: 64'h0000_0000_0000_3000, size: 64'd1,   beats: 1};
        vecs[4] = '{id: 1, addr: 64'hFFFF_FFFF_FFFF_FFC0, size: 64'd129, beats: 3};
        exp_order = '{0, 1, 2, 3, 0};

        req_addr = '0;
        req_size = '0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        settle();
        chk_all_zero("reset");
        reset = 1'b0;

        foreach (vecs[v]) begin
            do_xfer(vecs[v].id, vecs[v].addr, vecs[v].size, vecs[v].beats);
        end

        // Fairness: everyone requests continuously; the second round wraps back to 0.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[64*i +: 64] = 64'(i) << 8;
            req_size[64*i +: 64] = 64'd64;
        end
        req_valid       = 4'hF;
        read_data_ready = 1'b1;
        req_data_ack    = 4'hF;
        read_data       = pat(7);
        ngr = 0;
        bad = 0;
        for (int c = 0; c < 60 && ngr < 5; c++) begin
            tick();
            settle();
            if ($countones(req_grant) > 1 || $countones(req_data_valid) > 1 ||
                $countones(req_done) > 1) begin
                bad++;
            end
            if (req_grant != 4'b0) begin
                gi = 0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (req_grant[k]) gi = k;
                end
                order[ngr] = gi;
                ngr++;
            end
        end
        chk("fair_count", 512'(ngr), 512'(5));
        for (int i = 0; i < 5; i++) begin
            chk("fair_order", 512'(order[i]), 512'(exp_order[i]));
        end
        chk("fair_onehot", 512'(bad), 512'(0));

        // Backpressure: read_ready low for 10 cycles in ISSUE.
        do_reset();
        tick();
        req_valid = 4'b0001;
        req_addr[0 +: 64] = 64'h5000;
        req_size[0 +: 64] = 64'd64;
        read_ready = 1'b0;
        settle();
        chk("bp_idle_req", 512'(read_req), 512'(1'b0));
        for (int i = 0; i < 10; i++) begin
            tick();
            settle();
            chk("bp_read_req", 512'(read_req), 512'(1'b0));
            chk("bp_busy", 512'(busy), 512'(1'b1));
            chk("bp_grant", 512'(req_grant), 512'(4'b0));
        end
        tick();
        read_ready = 1'b1;
        settle();
        chk("bp_release_req", 512'(read_req), 512'(1'b1));
        chk("bp_release_grant", 512'(req_grant), 512'(4'b0001));
        req_valid = '0;
        tick();
        read_data_ready = 1'b1;
        req_data_ack    = 4'b0001;
        settle();
        chk("bp_beat_ack", 512'(read_data_ack), 512'(1'b1));
        tick();
        read_data_ready = 1'b0;
        req_data_ack    = '0;
        settle();
        chk("bp_done", 512'(req_done), 512'(4'b0001));

        // Size 65 rounds to two beats; acks from a non-owner are ignored.
        do_reset();
        tick();
        req_valid = 4'b1000;
        req_addr[192 +: 64] = 64'h6000;
        req_size[192 +: 64] = 64'd65;
        settle();
        tick();
        settle();
        chk("fa_grant", 512'(req_grant), 512'(4'b1000));
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            read_data_ready = 1'b1;
            req_data_ack    = 4'b0001;
            settle();
            chk("fa_foreign_ack", 512'(read_data_ack), 512'(1'b0));
            chk("fa_dvalid", 512'(req_data_valid), 512'(4'b1000));
        end
        tick();
        req_data_ack = 4'b1000;
        settle();
        chk("fa_beat1_ack", 512'(read_data_ack), 512'(1'b1));
        tick();
        settle();
        chk("fa_no_early_done", 512'(req_done), 512'(4'b0));
        chk("fa_still_busy", 512'(busy), 512'(1'b1));
        chk("fa_beat2_ack", 512'(read_data_ack), 512'(1'b1));
        tick();
        read_data_ready = 1'b0;
        req_data_ack    = '0;
        settle();
        chk("fa_done", 512'(req_done), 512'(4'b1000));
        chk("fa_idle", 512'(busy), 512'(1'b0));

        // Zero size: grant and done pulse together, no DMA request, next search starts at 3.
        do_reset();
        tick();
        req_valid = 4'b0100;
        req_size[128 +: 64] = 64'd0;
        settle();
        chk("zs_idle_req", 512'(read_req), 512'(1'b0));
        tick();
        settle();
        chk("zs_grant", 512'(req_grant), 512'(4'b0100));
        chk("zs_done", 512'(req_done), 512'(4'b0100));
        chk("zs_read_req", 512'(read_req), 512'(1'b0));
        chk("zs_busy", 512'(busy), 512'(1'b0));
        req_valid = 4'b1011;
        req_size[0 +: 64]   = 64'd64;
        req_size[64 +: 64]  = 64'd64;
        req_size[192 +: 64] = 64'd64;
        req_addr[192 +: 64] = 64'h9000;
        tick();
        settle();
        chk("zs_no_regrant", 512'(req_grant), 512'(4'b0));
        chk("zs_no_redone", 512'(req_done), 512'(4'b0));
        chk("zs_still_no_req", 512'(read_req), 512'(1'b0));
        tick();
        settle();
        chk("zs_next_req", 512'(read_req), 512'(1'b1));
        chk("zs_next_grant", 512'(req_grant), 512'(4'b1000));
        chk("zs_next_addr", 512'(read_addr), 512'(64'h9000));
        req_valid = '0;
        tick();
        read_data_ready = 1'b1;
        req_data_ack    = 4'b1000;
        settle();
        chk("zs_next_ack", 512'(read_data_ack), 512'(1'b1));
        tick();
        read_data_ready = 1'b0;
        req_data_ack    = '0;
        settle();
        chk("zs_next_done", 512'(req_done), 512'(4'b1000));

        // Reset in the middle of a 4-beat transfer.
        do_reset();
        tick();
        req_valid = 4'b0010;
        req_addr[64 +: 64] = 64'h7000;
        req_size[64 +: 64] = 64'd256;
        settle();
        tick();
        settle();
        chk("mr_grant", 512'(req_grant), 512'(4'b0010));
        req_valid = '0;
        tick();
        read_data_ready = 1'b1;
        req_data_ack    = 4'b0010;
        settle();
        chk("mr_beat1_ack", 512'(read_data_ack), 512'(1'b1));
        tick();
        reset = 1'b1;
        tick();
        settle();
        chk_all_zero("mid_reset");
        reset           = 1'b0;
        read_data_ready = 1'b0;
        req_data_ack    = '0;
        do_xfer(2, 64'h8000, 64'd64, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
